dma_bus_arbiter: RTL and testbench
==================================

Name: dma_bus_arbiter

Overview:
- Owns the single shared memory bus between the CPU and DMA_controller. Sits directly upstream of the DMA engine: it answers BR with BG and steers address, data and write strobes to memory.
- Grants the bus to DMA only after any in-flight CPU access completes. Stalls the CPU while DMA owns the bus, then hands the bus back after a one-cycle turnaround.
- Counts DMA words written per grant and flags protocol violations.

Parameters:
- WORD_SIZE, 16, address/data width.
- CNT_W, 8, width of the DMA word counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_read_m  input  1  CPU requests memory read this cycle.
- cpu_write_m  input  1  CPU requests memory write this cycle.
- cpu_mem_busy  input  1  CPU access currently in flight (multi-cycle memory).
- cpu_address  input  WORD_SIZE  CPU memory address.
- cpu_data  input  WORD_SIZE  CPU write data.
- dma_br  input  1  bus request from DMA_controller (its BR).
- dma_use_bus  input  1  DMA write strobe (its use_bus).
- dma_address  input  WORD_SIZE  DMA target address (its o_address).
- dma_data  input  WORD_SIZE  word from the external device, selected by DMA idx.
- bg  output  1  bus grant to DMA (its BG).
- cpu_stall  output  1  CPU must hold its next memory request.
- mem_read  output  1  read strobe to memory.
- mem_write  output  1  write strobe to memory.
- mem_address  output  WORD_SIZE  muxed address.
- mem_data  output  WORD_SIZE  muxed write data.
- dma_word_count  output  CNT_W  DMA writes in the current/last grant.
- bus_error  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (synchronous, dominates everything):
  - state=IDLE; bg=0; dma_word_count=0; bus_error=0.
  - A reset mid-grant drops bg at that edge. DMA sees the grant removed.
- States, encoded IDLE=0, WAIT_CPU=1, GRANT=2, RELEASE=3:
  - IDLE, dma_br=1, cpu_mem_busy=0: go to GRANT; bg<=1 (one-cycle BR-to-BG latency); dma_word_count<=0.
  - IDLE, dma_br=1, cpu_mem_busy=1: go to WAIT_CPU.
  - IDLE, dma_br=0: stay in IDLE.
  - WAIT_CPU, cpu_mem_busy=0: go to GRANT; bg<=1; count<=0.
  - WAIT_CPU, cpu_mem_busy still 1: stay in WAIT_CPU.
  - WAIT_CPU, dma_br drops (withdrawn): return to IDLE without granting.
  - GRANT, dma_br=1: stay in GRANT.
  - GRANT, dma_br=0: go to RELEASE; bg<=0.
  - RELEASE: go to IDLE unconditionally. This is the one turnaround cycle in which neither master drives the bus.
- cpu_stall (combinational) = (state!=IDLE) | (state==IDLE & dma_br).
  - The CPU must not start a new access while stalled.
  - An access already in flight (cpu_mem_busy) is allowed to complete.
- Bus mux (combinational):
  - bg=1: mem_address=dma_address, mem_data=dma_data, mem_write=dma_use_bus, mem_read=0.
  - bg=0 and state!=RELEASE: CPU signals pass through.
  - RELEASE: all strobes 0, address/data 0.
- dma_word_count:
  - Increments on every cycle with bg=1 & dma_use_bus=1.
  - Saturates at 2^CNT_W-1.
  - Holds its value after the grant ends until the next grant starts.
- bus_error is set, and held until reset, when:
  - dma_use_bus=1 while bg=0; or
  - bg=1 while cpu_read_m or cpu_write_m is asserted (CPU ignored stall).
  - An offending DMA write is still suppressed: mem_write=0.
- Simultaneous events:
  - dma_br rising in the same cycle cpu_mem_busy falls (IDLE): the grant is issued next cycle.
  - dma_br dropping and re-rising back-to-back: RELEASE is always traversed, so the minimum gap between grants is 2 cycles.

Decomposition:
- Shared package holds:
  - state encodings ARB_IDLE/ARB_WAIT_CPU/ARB_GRANT/ARB_RELEASE;
  - WORD_SIZE define (already `WORD_SIZE 16 in the codebase);
  - CNT_W default.
- One natural sub-module: dma_word_counter (saturating counter with clear and enable). The FSM and mux stay in the top.

Test Plan:
- Idle CPU, dma_br=1 at cycle 0 → bg=1 at cycle 1. Then 12 dma_use_bus pulses with dma_address 0x0100..0x010B → 12 mem_write pulses on those addresses, dma_word_count=12. dma_br=0 → bg=0 next edge, one RELEASE cycle with strobes 0, cpu_stall=0 after.
- cpu_mem_busy=1 for 4 cycles when dma_br rises → state WAIT_CPU, bg=0 for those 4 cycles, bg=1 one cycle after busy falls, cpu_stall=1 throughout.
- dma_br pulsed 1 cycle during WAIT_CPU then dropped → returns to IDLE, bg never asserted, count unchanged.
- dma_use_bus=1 with bg=0 → mem_write=0, bus_error=1 and stays 1 until reset.
- reset asserted 3 cycles into GRANT → bg=0, count=0, state IDLE after that edge. dma_br still 1 → bg=1 again one cycle after reset release.
- CNT_W=4, 20 DMA writes in one grant → dma_word_count saturates at 15.

Source files
------------

// File: rtl/dma_bus_arbiter_pkg.sv
// rtl/dma_bus_arbiter_pkg.sv - shared constants for the CPU/DMA memory bus arbiter
// Holds the arbiter state encodings, the bus word width and the default
// DMA word counter width used by dma_bus_arbiter and dma_word_counter.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package dma_bus_arbiter_pkg;

    localparam int unsigned ARB_WORD_SIZE = `WORD_SIZE;
    localparam int unsigned ARB_CNT_W     = 8;

    localparam logic [1:0] ARB_IDLE     = 2'd0;
    localparam logic [1:0] ARB_WAIT_CPU = 2'd1;
    localparam logic [1:0] ARB_GRANT    = 2'd2;
    localparam logic [1:0] ARB_RELEASE  = 2'd3;

endpackage

// File: rtl/dma_word_counter.sv
// rtl/dma_word_counter.sv - saturating DMA word counter with clear and enable
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear_i    : zero the count (wins over en_i)
//   en_i       : count one word this cycle
//   count_o    : current count, sticks at all-ones
module dma_word_counter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W = ARB_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - CPU/DMA shared memory bus arbiter with grant FSM and bus mux
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   cpu_read_m/cpu_write_m          : CPU memory strobes
//   cpu_mem_busy                    : CPU access still in flight
//   cpu_address/cpu_data            : CPU address and write data
//   dma_br/dma_use_bus              : DMA bus request and write strobe
//   dma_address/dma_data            : DMA address and write data
//   bg                              : bus grant to DMA
//   cpu_stall                       : CPU must hold off new accesses
//   mem_read/mem_write              : memory strobes
//   mem_address/mem_data            : muxed address and write data
//   dma_word_count                  : DMA writes in current/last grant
//   bus_error                       : sticky protocol-violation flag
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE = ARB_WORD_SIZE,
    parameter int unsigned CNT_W     = ARB_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_read_m,
    input  logic                 cpu_write_m,
    input  logic                 cpu_mem_busy,
    input  logic [WORD_SIZE-1:0] cpu_address,
    input  logic [WORD_SIZE-1:0] cpu_data,
    input  logic                 dma_br,
    input  logic                 dma_use_bus,
    input  logic [WORD_SIZE-1:0] dma_address,
    input  logic [WORD_SIZE-1:0] dma_data,
    output logic                 bg,
    output logic                 cpu_stall,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_data,
    output logic [CNT_W-1:0]     dma_word_count,
    output logic                 bus_error
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       bg_q;
    logic       bg_d;
    logic       err_q;
    logic       err_d;
    logic       cnt_clear;

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (dma_br) begin
                    if (cpu_mem_busy) begin
                        state_d = ARB_WAIT_CPU;
                    end else begin
                        state_d   = ARB_GRANT;
                        cnt_clear = 1'b1;
                    end
                end
            end
            ARB_WAIT_CPU: begin
                // A withdrawn request wins even if the CPU finishes this cycle.
                if (!dma_br) begin
                    state_d = ARB_IDLE;
                end else if (!cpu_mem_busy) begin
                    state_d   = ARB_GRANT;
                    cnt_clear = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (!dma_br) begin
                    state_d = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        bg_d  = (state_d == ARB_GRANT);
        err_d = err_q
              | (dma_use_bus & ~bg_q)
              | (bg_q & (cpu_read_m | cpu_write_m));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            bg_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bg_q    <= bg_d;
            err_q   <= err_d;
        end
    end

    dma_word_counter #(
        .CNT_W (CNT_W)
    ) u_word_counter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cnt_clear),
        .en_i    (bg_q & dma_use_bus),
        .count_o (dma_word_count)
    );

    // The RELEASE cycle parks the bus so neither master drives it.
    always_comb begin
        mem_read    = cpu_read_m;
        mem_write   = cpu_write_m;
        mem_address = cpu_address;
        mem_data    = cpu_data;
        if (bg_q) begin
            mem_read    = 1'b0;
            mem_write   = dma_use_bus;
            mem_address = dma_address;
            mem_data    = dma_data;
        end else if (state_q == ARB_RELEASE) begin
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            mem_address = '0;
            mem_data    = '0;
        end
    end

    assign bg        = bg_q;
    assign bus_error = err_q;
    assign cpu_stall = (state_q != ARB_IDLE) | dma_br;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb/tb_dma_bus_arbiter.sv - self-checking bench for dma_bus_arbiter
module tb_dma_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read_m, cpu_write_m, cpu_mem_busy;
    logic [15:0] cpu_address, cpu_data;
    logic        dma_br, dma_use_bus;
    logic [15:0] dma_address, dma_data;
    logic        bg, cpu_stall, mem_read, mem_write, bus_error;
    logic [15:0] mem_address, mem_data;
    logic [7:0]  cnt8;
    logic        bg4, stall4, rd4, wr4, err4;
    logic [15:0] addr4, data4;
    logic [3:0]  cnt4;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: who owns the bus, expressed as plain flags.
    bit m_owned, m_waiting, m_turn, m_err;
    int m_cnt;

    always #5 clk = ~clk;

    dma_bus_arbiter #(.WORD_SIZE(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_read_m(cpu_read_m), .cpu_write_m(cpu_write_m), .cpu_mem_busy(cpu_mem_busy),
        .cpu_address(cpu_address), .cpu_data(cpu_data),
        .dma_br(dma_br), .dma_use_bus(dma_use_bus), .dma_address(dma_address), .dma_data(dma_data),
        .bg(bg), .cpu_stall(cpu_stall), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_data(mem_data),
        .dma_word_count(cnt8), .bus_error(bus_error)
    );

    dma_bus_arbiter #(.WORD_SIZE(16), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .cpu_read_m(cpu_read_m), .cpu_write_m(cpu_write_m), .cpu_mem_busy(cpu_mem_busy),
        .cpu_address(cpu_address), .cpu_data(cpu_data),
        .dma_br(dma_br), .dma_use_bus(dma_use_bus), .dma_address(dma_address), .dma_data(dma_data),
        .bg(bg4), .cpu_stall(stall4), .mem_read(rd4), .mem_write(wr4),
        .mem_address(addr4), .mem_data(data4),
        .dma_word_count(cnt4), .bus_error(err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int cnt, input int maxv);
        return 32'((cnt > maxv) ? maxv : cnt);
    endfunction

    task automatic check_outputs();
        logic [15:0] ea, ed;
        logic        er, ew;
        if (m_owned) begin
            er = 1'b0; ew = dma_use_bus; ea = dma_address; ed = dma_data;
        end else if (m_turn) begin
            er = 1'b0; ew = 1'b0; ea = 16'h0; ed = 16'h0;
        end else begin
            er = cpu_read_m; ew = cpu_write_m; ea = cpu_address; ed = cpu_data;
        end
        chk("bg", 32'(bg), 32'(m_owned));
        chk("cpu_stall", 32'(cpu_stall), 32'(m_owned | m_waiting | m_turn | dma_br));
        chk("mem_read", 32'(mem_read), 32'(er));
        chk("mem_write", 32'(mem_write), 32'(ew));
        chk("mem_address", 32'(mem_address), 32'(ea));
        chk("mem_data", 32'(mem_data), 32'(ed));
        chk("word_count", 32'(cnt8), sat(m_cnt, 255));
        chk("bus_error", 32'(bus_error), 32'(m_err));
        chk("bg_cnt4", 32'(bg4), 32'(m_owned));
        chk("word_count_cnt4", 32'(cnt4), sat(m_cnt, 15));
    endtask

    task automatic model_update();
        if (reset) begin
            m_owned = 0; m_waiting = 0; m_turn = 0; m_err = 0; m_cnt = 0;
        end else begin
            if ((dma_use_bus && !m_owned) || (m_owned && (cpu_read_m || cpu_write_m)))
                m_err = 1;
            if (m_owned && dma_use_bus)
                m_cnt++;
            if (m_turn) begin
                m_turn = 0;
            end else if (m_owned) begin
                if (!dma_br) begin
                    m_owned = 0; m_turn = 1;
                end
            end else if (m_waiting) begin
                if (!dma_br) begin
                    m_waiting = 0;
                end else if (!cpu_mem_busy) begin
                    m_waiting = 0; m_owned = 1; m_cnt = 0;
                end
            end else if (dma_br) begin
                if (cpu_mem_busy) m_waiting = 1;
                else begin
                    m_owned = 1; m_cnt = 0;
                end
            end
        end
    endtask

    // Inputs are changed at posedge+1; checks happen at the following negedge.
    task automatic cycle();
        #4;
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        reset = 1; cpu_read_m = 0; cpu_write_m = 0; cpu_mem_busy = 0;
        cpu_address = 16'h1234; cpu_data = 16'h5678;
        dma_br = 0; dma_use_bus = 0; dma_address = 16'h0; dma_data = 16'h0;
        @(posedge clk);
        model_update();
        #1;
        cycle();
        chk("reset_bg", 32'(bg), 32'd0);
        chk("reset_count", 32'(cnt8), 32'd0);
        chk("reset_error", 32'(bus_error), 32'd0);
        reset = 0;
        cycle();

        // Basic grant with 12 DMA writes.
        dma_br = 1;
        cycle();
        chk("t1_bg_latency", 32'(bg), 32'd1);
        for (int i = 0; i < 12; i++) begin
            dma_use_bus = 1;
            dma_address = 16'h0100 + 16'(i);
            dma_data = 16'($urandom);
            cycle();
        end
        dma_use_bus = 0;
        chk("t1_count12", 32'(cnt8), 32'd12);
        dma_br = 0;
        cycle();
        chk("t1_bg_drop", 32'(bg), 32'd0);
        cpu_address = 16'hBEEF;
        #4;
        chk("t1_release_addr", 32'(mem_address), 32'd0);
        chk("t1_release_write", 32'(mem_write), 32'd0);
        #1;
        @(posedge clk); model_update(); #1;
        chk("t1_stall_after", 32'(cpu_stall), 32'd0);
        cycle();

        // CPU access in flight holds off the grant.
        cpu_mem_busy = 1; dma_br = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t2_wait_bg", 32'(bg), 32'd0);
            chk("t2_wait_stall", 32'(cpu_stall), 32'd1);
        end
        cpu_mem_busy = 0;
        cycle();
        chk("t2_grant", 32'(bg), 32'd1);
        dma_br = 0;
        cycle();
        cycle();

        // Request withdrawn during the wait.
        chk("t3_count_before", 32'(cnt8), 32'd0);
        cpu_mem_busy = 1; dma_br = 1;
        cycle();
        dma_br = 0;
        cycle();
        cpu_mem_busy = 0;
        cycle();
        chk("t3_no_grant", 32'(bg), 32'd0);
        chk("t3_count_after", 32'(cnt8), 32'd0);

        // DMA strobe without a grant.
        dma_use_bus = 1;
        #4;
        chk("t4_write_suppressed", 32'(mem_write), 32'd0);
        #1;
        @(posedge clk); model_update(); #1;
        dma_use_bus = 0;
        chk("t4_error_set", 32'(bus_error), 32'd1);
        repeat (3) cycle();
        chk("t4_error_sticky", 32'(bus_error), 32'd1);
        reset = 1;
        cycle();
        reset = 0;
        chk("t4_error_cleared", 32'(bus_error), 32'd0);

        // Reset in the middle of a grant.
        dma_br = 1;
        cycle();
        dma_use_bus = 1;
        repeat (3) cycle();
        chk("t5_count3", 32'(cnt8), 32'd3);
        reset = 1;
        cycle();
        chk("t5_reset_bg", 32'(bg), 32'd0);
        chk("t5_reset_count", 32'(cnt8), 32'd0);
        reset = 0; dma_use_bus = 0;
        cycle();
        chk("t5_regrant", 32'(bg), 32'd1);

        // Saturation of both counter widths.
        dma_use_bus = 1;
        repeat (20) cycle();
        chk("t6_sat4", 32'(cnt4), 32'd15);
        chk("t6_count20", 32'(cnt8), 32'd20);
        repeat (240) cycle();
        chk("t6_sat8", 32'(cnt8), 32'd255);
        dma_use_bus = 0; dma_br = 0;
        cycle();

        // Re-request during RELEASE: grant gap is two cycles.
        dma_br = 1;
        cycle();
        chk("t7_gap", 32'(bg), 32'd0);
        cycle();
        chk("t7_regrant", 32'(bg), 32'd1);
        chk("t7_count_cleared", 32'(cnt8), 32'd0);
        dma_br = 0;
        cycle();
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(99) == 0);
            if ($urandom_range(7) == 0) dma_br = ~dma_br;
            cpu_mem_busy = ($urandom_range(2) == 0);
            dma_use_bus = m_owned ? 1'($urandom_range(1)) : ($urandom_range(39) == 0);
            if (!(m_owned | m_waiting | m_turn | dma_br)) begin
                cpu_read_m  = 1'($urandom_range(1));
                cpu_write_m = ~cpu_read_m & 1'($urandom_range(1));
            end else begin
                cpu_read_m  = ($urandom_range(49) == 0);
                cpu_write_m = 1'b0;
            end
            cpu_address = 16'($urandom);
            cpu_data    = 16'($urandom);
            dma_address = 16'($urandom);
            dma_data    = 16'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
